miriscv_data_mem_responder: RTL and testbench

MIRISCV_DATA_MEM_RESPONDER -- requirements
Module: miriscv_data_mem_responder

---
 rtl/miriscv_data_mem_responder_if.sv | 21 ++
 rtl/miriscv_data_mem_responder.sv | 103 ++++++++++
 tb/tb_miriscv_data_mem_responder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/miriscv_data_mem_responder_if.sv
// Data-memory bus between the core memory stage (master) and the memory responder (slave).
interface miriscv_data_mem_responder_if;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;

  modport master (
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_rvalid_o, data_rdata_o, data_err_o
  );

  modport slave (
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_rvalid_o, data_rdata_o, data_err_o
  );
endinterface

// File: rtl/miriscv_data_mem_responder.sv
// Zero-wait data memory with a fixed LATENCY-deep in-order response pipeline.
// Optional address/byte-enable checking is enabled by defining MIRISCV_DMEM_ERR_EN.
module miriscv_data_mem_responder #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned LATENCY   = 1
) (
  input logic                          clk_i,
  input logic                          rst_i,
  miriscv_data_mem_responder_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);

  logic [31:0]      mem_r [MEM_WORDS];
  logic [IDX_W-1:0] idx_s;
  logic             accept_s;
  logic             oob_s;
  logic             be_bad_s;
  logic             err_s;
  logic             wr_en_s;
  logic [31:0]      rd_word_s;
  logic [31:0]      resp_data_s;
  logic             unused_s;

  logic [LATENCY-1:0] valid_r;
  logic [LATENCY-1:0] err_r;
  logic [31:0]        rdata_r [LATENCY];

  // Naturally aligned byte, halfword or word enable patterns
  function automatic logic be_aligned(input logic [3:0] be);
    logic ok;
    case (be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: ok = 1'b1;
      4'b0011, 4'b1100:                   ok = 1'b1;
      4'b1111:                            ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Request decode: acceptance, indexing, error classification and load data
  always_comb begin
    accept_s  = bus.data_req_i & ~rst_i;
    idx_s     = bus.data_addr_i[IDX_W+1:2];
    rd_word_s = mem_r[idx_s];
`ifdef MIRISCV_DMEM_ERR_EN
    oob_s     = |bus.data_addr_i[31:IDX_W+2];
    be_bad_s  = bus.data_we_i & ~be_aligned(bus.data_be_i);
`else
    oob_s     = 1'b0;
    be_bad_s  = 1'b0;
`endif
    err_s     = oob_s | be_bad_s;
    wr_en_s   = accept_s & bus.data_we_i & ~err_s;
    if (bus.data_we_i || err_s) begin
      resp_data_s = 32'h0000_0000;
    end else begin
      resp_data_s = rd_word_s;
    end
  end

`ifdef MIRISCV_DMEM_ERR_EN
  assign unused_s = ^bus.data_addr_i[1:0];
`else
  assign unused_s = ^{bus.data_addr_i[31:IDX_W+2], bus.data_addr_i[1:0]};
`endif

  // Storage array: byte-lane writes, deliberately never reset
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      for (int k = 0; k < 4; k++) begin
        if (bus.data_be_i[k]) begin
          mem_r[idx_s][8*k +: 8] <= bus.data_wdata_i[8*k +: 8];
        end
      end
    end
  end

  // Response pipeline; stage 0 captures on the accept edge, rdata/err are zero when not valid
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_r <= {LATENCY{1'b0}};
      err_r   <= {LATENCY{1'b0}};
      for (int i = 0; i < int'(LATENCY); i++) begin
        rdata_r[i] <= 32'h0000_0000;
      end
    end else begin
      valid_r[0] <= accept_s;
      err_r[0]   <= accept_s & err_s;
      rdata_r[0] <= accept_s ? resp_data_s : 32'h0000_0000;
      for (int i = 1; i < int'(LATENCY); i++) begin
        valid_r[i] <= valid_r[i-1];
        err_r[i]   <= err_r[i-1];
        rdata_r[i] <= rdata_r[i-1];
      end
    end
  end

  assign bus.data_rvalid_o = valid_r[LATENCY-1];
  assign bus.data_rdata_o  = rdata_r[LATENCY-1];
  assign bus.data_err_o    = err_r[LATENCY-1];

endmodule

// File: tb/tb_miriscv_data_mem_responder.sv
// Bench: two responders (LATENCY 1 and 3) share one directed stimulus stream and a request-level model.
module tb_miriscv_data_mem_responder;

`ifdef MIRISCV_DMEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam int HMAX = 2048;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  miriscv_data_mem_responder_if bus1();
  miriscv_data_mem_responder_if bus3();

  miriscv_data_mem_responder #(.MEM_WORDS(1024), .LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .bus(bus1)
  );
  miriscv_data_mem_responder #(.MEM_WORDS(1024), .LATENCY(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .bus(bus3)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // request history per clock edge: accepted?, reset?, response payload
  bit          h_req  [HMAX];
  bit          h_rst  [HMAX];
  logic [31:0] h_data [HMAX];
  bit          h_err  [HMAX];
  logic [31:0] mmem   [1024];

  logic [31:0] m_addr;
  logic [9:0]  m_word;
  bit          m_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // expected output in the cycle after edge cyc: the request accepted LAT edges earlier, unless a reset edge intervened
  task automatic check_port(input string tag, input int lat, input logic v, input logic [31:0] d, input logic e);
    int  src;
    bit  flushed;
    bit  ev;
    logic [31:0] ed;
    bit  ee;
    src = cyc + 1 - lat;
    flushed = 1'b0;
    ev = 1'b0; ed = 32'h0; ee = 1'b0;
    for (int k = src; k <= cyc; k++) begin
      if (k >= 0 && h_rst[k]) flushed = 1'b1;
    end
    if (src >= 0 && !flushed && h_req[src]) begin
      ev = 1'b1; ed = h_data[src]; ee = h_err[src];
    end
    check({tag, " rvalid"}, {31'd0, v}, {31'd0, ev});
    check({tag, " rdata"},  d, ed);
    check({tag, " err"},    {31'd0, e}, {31'd0, ee});
  endtask

  // model + compare: record the request seen at each edge, then check both responders
  always @(posedge clk) begin
    h_rst[cyc]  = rst;
    h_req[cyc]  = bus1.data_req_i && !rst;
    h_data[cyc] = 32'h0;
    h_err[cyc]  = 1'b0;
    if (h_req[cyc]) begin
      m_addr = bus1.data_addr_i;
      m_word = m_addr[11:2];
      m_bad  = bus1.data_we_i && !(bus1.data_be_i inside {4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                                            4'b0011, 4'b1100, 4'b1111});
      h_err[cyc] = ERR_EN && ((m_addr >= 32'd4096) || m_bad);
      if (bus1.data_we_i) begin
        if (!h_err[cyc]) begin
          for (int k = 0; k < 4; k++) begin
            if (bus1.data_be_i[k]) mmem[m_word][8*k +: 8] = bus1.data_wdata_i[8*k +: 8];
          end
        end
      end else begin
        h_data[cyc] = h_err[cyc] ? 32'h0 : mmem[m_word];
      end
    end
    #1;
    check_port("L1", 1, bus1.data_rvalid_o, bus1.data_rdata_o, bus1.data_err_o);
    check_port("L3", 3, bus3.data_rvalid_o, bus3.data_rdata_o, bus3.data_err_o);
    cyc++;
  end

  task automatic drive(input logic r, input logic q, input logic w, input logic [3:0] be,
                       input logic [31:0] a, input logic [31:0] d);
    rst = r;
    bus1.data_req_i = q; bus1.data_we_i = w; bus1.data_be_i = be;
    bus1.data_addr_i = a; bus1.data_wdata_i = d;
    bus3.data_req_i = q; bus3.data_we_i = w; bus3.data_be_i = be;
    bus3.data_addr_i = a; bus3.data_wdata_i = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
  endtask

  task automatic st(input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
    drive(1'b0, 1'b1, 1'b1, be, a, d);
  endtask

  task automatic ld(input logic [31:0] a);
    drive(1'b0, 1'b1, 1'b0, 4'b0000, a, 32'h0);
  endtask

  logic [3:0] be_tab [8];
  logic [31:0] r_addr;

  initial begin
    be_tab[0] = 4'b1111; be_tab[1] = 4'b0001; be_tab[2] = 4'b1000; be_tab[3] = 4'b0011;
    be_tab[4] = 4'b1100; be_tab[5] = 4'b0110; be_tab[6] = 4'b0000; be_tab[7] = 4'b0100;

    // reset, including a store presented during reset that must be dropped
    drive(1'b1, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 4'b1111, 32'h0000_0014, 32'hBAD0_BAD0);
    drive(1'b1, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
    check("reset rvalid1", {31'd0, bus1.data_rvalid_o}, 32'd0);
    check("reset rdata3", bus3.data_rdata_o, 32'h0);

    for (int i = 0; i < 16; i++) st(4'b1111, 32'(i * 4), 32'(i));
    idle(4);

    // eight back-to-back loads, LATENCY 3 returns 0..7 in order
    for (int i = 0; i < 8; i++) begin
      ld(32'(i * 4));
      if (i == 1) check("L3 not yet valid", {31'd0, bus3.data_rvalid_o}, 32'd0);
      if (i >= 2) begin
        check("L3 seq rvalid", {31'd0, bus3.data_rvalid_o}, 32'd1);
        check("L3 seq rdata", bus3.data_rdata_o, 32'(i - 2));
      end
    end
    idle(1); check("L3 seq rdata 6", bus3.data_rdata_o, 32'd6);
    idle(1); check("L3 seq rdata 7", bus3.data_rdata_o, 32'd7);
    idle(1); check("L3 seq end", {31'd0, bus3.data_rvalid_o}, 32'd0);
    idle(2);

    // full store then load, then a single-lane update
    st(4'b1111, 32'h10, 32'hDEAD_BEEF);
    check("store resp rvalid", {31'd0, bus1.data_rvalid_o}, 32'd1);
    check("store resp rdata", bus1.data_rdata_o, 32'h0);
    ld(32'h10);
    check("load after store", bus1.data_rdata_o, 32'hDEAD_BEEF);
    st(4'b0100, 32'h10, 32'h00AA_0000);
    ld(32'h10);
    check("lane2 merge", bus1.data_rdata_o, 32'hDEAA_BEEF);
    check("model word4", mmem[4], 32'hDEAA_BEEF);
    st(4'b0000, 32'h10, 32'hFFFF_FFFF);
    ld(32'h10);
    check("be0000 no write", bus1.data_rdata_o, 32'hDEAA_BEEF);

    // misaligned enables
    st(4'b1111, 32'h20, 32'hCAFE_F00D);
    st(4'b0110, 32'h20, 32'h1234_5678);
    check("be0110 err", {31'd0, bus1.data_err_o}, {31'd0, ERR_EN});
    ld(32'h20);
    check("be0110 result", bus1.data_rdata_o, ERR_EN ? 32'hCAFE_F00D : 32'hCA34_560D);

    // out-of-range address aliases or errors
    st(4'b1111, 32'h0, 32'h1357_9BDF);
    ld(32'h1000);
    check("alias load rdata", bus1.data_rdata_o, ERR_EN ? 32'h0 : 32'h1357_9BDF);
    check("alias load err", {31'd0, bus1.data_err_o}, {31'd0, ERR_EN});
    st(4'b1111, 32'h1004, 32'h2468_ACE0);
    ld(32'h4);
    check("alias store", bus1.data_rdata_o, ERR_EN ? 32'h1 : 32'h2468_ACE0);
    idle(4);

    // reset drops in-flight LATENCY-3 responses; earlier store survives
    st(4'b1111, 32'h30, 32'hA5A5_A5A5);
    idle(4);
    ld(32'h30);
    ld(32'h30);
    drive(1'b1, 1'b1, 1'b1, 4'b1111, 32'h30, 32'hFFFF_0000);
    check("flush L3 a", {31'd0, bus3.data_rvalid_o}, 32'd0);
    idle(1);
    check("flush L3 b", {31'd0, bus3.data_rvalid_o}, 32'd0);
    idle(1);
    check("flush L3 c", {31'd0, bus3.data_rvalid_o}, 32'd0);
    ld(32'h30);
    check("post-reset L1", bus1.data_rdata_o, 32'hA5A5_A5A5);
    idle(1);
    check("post-reset L3 early", {31'd0, bus3.data_rvalid_o}, 32'd0);
    idle(1);
    check("post-reset L3", bus3.data_rdata_o, 32'hA5A5_A5A5);
    idle(2);

    // mixed back-to-back traffic, compared every cycle by the model
    for (int i = 0; i < 48; i++) begin
      r_addr = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 4) == 0) r_addr = r_addr | (32'($urandom_range(1, 7)) << 12);
      if ($urandom_range(0, 1) == 0)
        st(be_tab[$urandom_range(0, 7)], r_addr, $urandom);
      else
        ld(r_addr);
    end
    idle(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
